// File: rtl/wb_commit_trace_pkg.sv
// Shared pipeline definitions used by the writeback commit trace.
// The trace entry packs {rd, data, pc, seq}, so its width depends on SEQ_W.
package wb_commit_trace_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int XLEN          = 32;
  localparam int TRACE_FIXED_W = REG_ADDR_W + XLEN + XLEN;

  function automatic int trace_entry_w(input int seq_w);
    return TRACE_FIXED_W + seq_w;
  endfunction

endpackage

// File: rtl/wb_trace_fifo_mem.sv
// Register-array storage for the commit trace FIFO.
// It has a synchronous write port, an asynchronous read port, and no reset.
module wb_trace_fifo_mem #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 85
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [ENTRY_W-1:0]       i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [ENTRY_W-1:0]       o_rdata
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/wb_commit_trace.sv
// Captures retired register-file writes into a FIFO drained over valid/ready.
// Every commit event consumes a sequence number, so dropped commits show up as gaps.
module wb_commit_trace
  import wb_commit_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wb_rf_enable,
  input  logic [REG_ADDR_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]         wb_data,
  input  logic [XLEN-1:0]         wb_pc,
  input  logic                    capture_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [REG_ADDR_W-1:0]   out_rd,
  output logic [XLEN-1:0]         out_data,
  output logic [XLEN-1:0]         out_pc,
  output logic [SEQ_W-1:0]        out_seq,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [7:0]              drop_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = trace_entry_w(SEQ_W);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [7:0]       DROP_MAX = 8'hFF;

  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic [SEQ_W-1:0]   r_seq;
  logic               r_overflow;
  logic [7:0]         r_drop_count;

  logic               w_commit;
  logic               w_pop;
  logic               w_full;
  logic               w_push;
  logic               w_drop;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;

  // x0 writes are architecturally invisible and never count as commits.
  assign w_commit = wb_rf_enable && (wb_rd != '0) && capture_en;
  assign w_full   = (r_count == FULL_CNT);
  assign w_pop    = out_valid && out_ready;
  assign w_push   = w_commit && (!w_full || w_pop);
  assign w_drop   = w_commit && w_full && !w_pop;
  assign w_wdata  = {wb_rd, wb_data, wb_pc, r_seq};

  wb_trace_fifo_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  assign {out_rd, out_data, out_pc, out_seq} = w_rdata;
  assign out_valid  = (r_count != '0);
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_seq        <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      if (w_commit) r_seq <= r_seq + SEQ_W'(1);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != DROP_MAX) r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

endmodule
